// File: rtl/i2s_receiver.sv
// 16-bit stereo I2S capture path: oversamples BCLK/LRCK/SDATA on CLOCK_50 and publishes
// left/right pairs with a one-cycle valid strobe, plus framing-error and link-idle status.
module i2s_receiver #(
  parameter int unsigned SAMPLE_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    i2sBitClock,
  input  logic                    i2sLeftRightSelect,
  input  logic                    i2sSoundData,
  output logic [SAMPLE_WIDTH-1:0] leftSample,
  output logic [SAMPLE_WIDTH-1:0] rightSample,
  output logic                    sampleValid,
  output logic                    frameError,
  output logic                    linkActive
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW  = 6;

  // Equal synchronizer depth on all pins keeps LRCK/SDATA aligned with the BCLK edge.
  logic [2:0] bclk_sync_q;
  logic [1:0] lr_sync_q;
  logic [1:0] sd_sync_q;

  logic [SAMPLE_WIDTH-2:0] shift_q, shift_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    held_q, held_d;
  logic                    prev_lr_q, prev_lr_d;
  logic                    synced_q, synced_d;
  logic [IdleW-1:0]        idle_q, idle_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    link_q, link_d;

  logic                    rise;
  logic                    lr;
  logic [SAMPLE_WIDTH-1:0] word;

  assign rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lr   = lr_sync_q[1];
  assign word = {shift_q, sd_sync_q[1]};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    held_d    = held_q;
    prev_lr_d = prev_lr_q;
    synced_d  = synced_q;
    idle_d    = idle_q;
    left_d    = left_q;
    right_d   = right_q;
    link_d    = link_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (rise) begin
      shift_d   = word[SAMPLE_WIDTH-2:0];
      idle_d    = '0;
      link_d    = 1'b1;
      prev_lr_d = lr;
      bit_cnt_d = (bit_cnt_q == {CntW{1'b1}}) ? bit_cnt_q : bit_cnt_q + CntW'(1);
      if (lr != prev_lr_q) begin
        // The bit just shifted in is the LSB of the word for channel prev_lr_q.
        bit_cnt_d = '0;
        if (!synced_q) begin
          synced_d = 1'b1;
        end else if (bit_cnt_q == CntW'(SAMPLE_WIDTH - 1)) begin
          if (!prev_lr_q) begin
            hold_d = word;
            held_d = 1'b1;
          end else if (held_q) begin
            left_d  = hold_q;
            right_d = word;
            valid_d = 1'b1;
            held_d  = 1'b0;
          end
        end else begin
          err_d  = 1'b1;
          held_d = 1'b0;
        end
      end
    end else begin
      if (idle_q != IdleW'(TIMEOUT_CYCLES)) begin
        idle_d = idle_q + IdleW'(1);
      end
      if (idle_d == IdleW'(TIMEOUT_CYCLES)) begin
        link_d    = 1'b0;
        synced_d  = 1'b0;
        bit_cnt_d = '0;
        held_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      held_q      <= 1'b0;
      prev_lr_q   <= 1'b0;
      synced_q    <= 1'b0;
      idle_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      link_q      <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], i2sBitClock};
      lr_sync_q   <= {lr_sync_q[0], i2sLeftRightSelect};
      sd_sync_q   <= {sd_sync_q[0], i2sSoundData};
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      held_q      <= held_d;
      prev_lr_q   <= prev_lr_d;
      synced_q    <= synced_d;
      idle_q      <= idle_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      link_q      <= link_d;
    end
  end

  assign leftSample  = left_q;
  assign rightSample = right_q;
  assign sampleValid = valid_q;
  assign frameError  = err_q;
  assign linkActive  = link_q;

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Deserializes a 16-bit stereo I2S stream (BCLK, LRCK, SDATA driven by an external master) into parallel left/right samples, with a one-cycle valid strobe per stereo frame.
- All logic runs on CLOCK_50, oversampling the I2S pins. Serves as the capture path for an ADC/line-in. Also acts as a loopback checker for the synthesizer's I2S output.
- Format: standard I2S, MSB first. Data changes on BCLK falling edge and is sampled on BCLK rising edge. LRCK toggles coincident with the LSB of the outgoing word (1-bit delay). LRCK=0 is left, LRCK=1 is right.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel word.
- TIMEOUT_CYCLES, 256, CLOCK_50 cycles without a BCLK rising edge before the link is declared idle.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- i2sBitClock  input  1  BCLK from the I2S master, asynchronous to CLOCK_50.
- i2sLeftRightSelect  input  1  LRCK.
- i2sSoundData  input  1  serial data.
- leftSample  output  SAMPLE_WIDTH  last complete left word.
- rightSample  output  SAMPLE_WIDTH  last complete right word.
- sampleValid  output  1  one-cycle pulse: leftSample/rightSample updated as a pair.
- frameError  output  1  one-cycle pulse: a word with a bit count other than SAMPLE_WIDTH was discarded.
- linkActive  output  1  high while BCLK edges arrive within TIMEOUT_CYCLES.

Behaviour:
- Reset: the block is asynchronous, active-low, and resets all registers to 0.
  - Outputs go to 0: leftSample, rightSample, sampleValid, frameError, linkActive.
  - Internal state also clears: synchronizers, shift register, bit counter, left-word holding register, prevLr, synced=0.
- Input sync:
  - Each of the three pins passes through a 2-FF synchronizer, identical depth for all three so they stay aligned.
  - A third BCLK register provides edge detect: rise = s2 & ~s3.
- Input timing: BCLK high and low phases must each be ≥4 CLOCK_50 cycles. The nominal source has ~18 cycles per phase.
- On each rise:
  - shift = {shift[W-2:0], sd}
  - bitCnt saturates at 63.
  - lr = synchronized LRCK is compared to prevLr, then prevLr <= lr.
- Word boundary (rise with lr != prevLr): the bit just shifted in is the LSB of a word belonging to channel prevLr.
  - synced=0: discard the word, set synced=1, no pulses. This is the first boundary after reset or timeout.
  - synced=1 and bitCnt+1 == SAMPLE_WIDTH:
    - prevLr=0: latch the word into the left holding register.
    - prevLr=1: leftSample <= holding, rightSample <= word, sampleValid pulses. A right word is only published if a valid left word was captured since the last publish; otherwise it is dropped silently.
  - synced=1 and count mismatch: discard the word, frameError pulses, and the left-held flag clears.
  - In all boundary cases bitCnt resets to 0 after the word is evaluated. The counted bits of a word are those since the previous boundary, including the boundary bit.
- Latency:
  - sampleValid and frameError are registered. They assert on the 3rd CLOCK_50 rising edge after the BCLK rising edge at the pin (+1 cycle of metastability uncertainty).
  - Each pulse is exactly 1 cycle wide.
- Output hold: leftSample and rightSample change only on a sampleValid cycle and hold otherwise.
- Timeout:
  - An idle counter increments every cycle without a rise and clears on a rise.
  - When it reaches TIMEOUT_CYCLES: linkActive <= 0, synced <= 0, bitCnt <= 0, left-held flag cleared. The idle counter saturates.
  - linkActive <= 1 on the next rise.
  - A partial word interrupted by a timeout produces no pulse.
- LRCK glitches: a toggle and return between two rises is invisible, because only rise-sampled values are used.
- Simultaneous: a boundary and a timeout cannot coincide, since a rise clears the idle counter. Reset overrides everything.

Test Plan:
- Drive BCLK with 19/19-cycle phases. Send L=16'hA5C3, R=16'h3C5A after one sync word → sampleValid pulses once, 1 cycle wide; leftSample=A5C3, rightSample=3C5A; frameError=0.
- Send 8 consecutive frames with L=n, R=~n → 8 sampleValid pulses, each carrying the matching pair. The first frame after reset is lost to sync, so send 9 frames to get 8 outputs.
- Send a 15-bit left word mid-stream → frameError pulses once. The following right word is dropped (no sampleValid). The next well-formed frame publishes normally.
- Stop BCLK for 300 cycles mid-word → linkActive falls at idle count 256 with no pulses. On restart, the first boundary only re-syncs, then the next full frame publishes.
- Assert reset_n=0 mid-frame → all outputs drop to 0 asynchronously. After release, behaviour matches power-up, with the first boundary discarded.
- Run BCLK at 4/4-cycle phases (minimum) with random pairs for 1000 frames → all pairs are received exactly, and the scoreboard shows zero frameError pulses.
